// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-entry fetch buffer with jump/branch redirect and flush.
// Define FETCH_PERF_COUNT_EN to add the StallCount decode-stall counter output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PcOut,
    output logic        InstrValid,
    input  logic        DecodeReady,
    input  logic        JumpEn,
    input  logic [25:0] JumpTarget,
    input  logic        BranchEn,
    input  logic [15:0] BranchOffset,
    input  logic        Flush,
    input  logic [31:0] FlushPc
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0] StallCount
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;

    assign pc_plus4   = pcout_q + 32'd4;
    assign branch_tgt = pc_plus4 + {{14{BranchOffset[15]}}, BranchOffset, 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcout_d    = pcout_q;
        imem_req   = 1'b0;
        InstrValid = 1'b0;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pcout_d = pc_q;
                    state_d = FULL;
                end
            end
            FULL: begin
                InstrValid = 1'b1;
                if (DecodeReady) begin
                    state_d = FETCH;
                    if (JumpEn)
                        pc_d = {pc_plus4[31:28], JumpTarget, 2'b00};
                    else if (BranchEn)
                        pc_d = branch_tgt;
                    else
                        pc_d = pc_plus4;
                end
            end
            DRAIN: begin
                // The ack of the request abandoned by the flush is swallowed here.
                if (imem_ack)
                    state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        if (Flush) begin
            pc_d    = FlushPc & 32'hFFFF_FFFC;
            instr_d = instr_q;
            pcout_d = pcout_q;
            state_d = (state_q == FETCH && !imem_ack) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            instr_q <= 32'h0;
            pcout_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
        end
    end

    assign imem_addr   = pc_q & 32'hFFFF_FFFC;
    assign Instruction = instr_q;
    assign PcOut       = pcout_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (Flush)
            stall_d = 16'h0;
        else if (state_q == FULL && !DecodeReady && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_q <= 16'h0;
        else
            stall_q <= stall_d;
    end

    assign StallCount = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; fetched words go through a scoreboard queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PcOut;
    logic        InstrValid;
    logic        DecodeReady;
    logic        JumpEn;
    logic [25:0] JumpTarget;
    logic        BranchEn;
    logic [15:0] BranchOffset;
    logic        Flush;
    logic [31:0] FlushPc;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] StallCount;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .Instruction  (Instruction),
        .PcOut        (PcOut),
        .InstrValid   (InstrValid),
        .DecodeReady  (DecodeReady),
        .JumpEn       (JumpEn),
        .JumpTarget   (JumpTarget),
        .BranchEn     (BranchEn),
        .BranchOffset (BranchOffset),
        .Flush        (Flush),
        .FlushPc      (FlushPc)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .StallCount   (StallCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, answer it in the same cycle, then check the presented word.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
        exp_t e;
        int   n = 0;
        while (imem_req !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("req_wait", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back('{pc: addr, instr: word});
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("valid_after_ack", {31'b0, InstrValid}, 32'd1);
        chk("req_in_full", {31'b0, imem_req}, 32'd0);
        chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instruction", Instruction, e.instr);
            chk("pcout", PcOut, e.pc);
        end
    endtask

    task automatic consume(input logic je, input logic [25:0] jt, input logic be,
                           input logic [15:0] bo, input logic [31:0] next_addr);
        DecodeReady  = 1'b1;
        JumpEn       = je;
        JumpTarget   = jt;
        BranchEn     = be;
        BranchOffset = bo;
        step();
        DecodeReady  = 1'b0;
        JumpEn       = 1'b0;
        JumpTarget   = 26'h0;
        BranchEn     = 1'b0;
        BranchOffset = 16'h0;
        chk("req_after_consume", {31'b0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, next_addr);
        chk("valid_after_consume", {31'b0, InstrValid}, 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        DecodeReady  = 1'b0;
        JumpEn       = 1'b0;
        JumpTarget   = 26'h0;
        BranchEn     = 1'b0;
        BranchOffset = 16'h0;
        Flush        = 1'b0;
        FlushPc      = 32'h0;

        #1;
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pcout", PcOut, 32'h0);
        chk("rst_valid", {31'b0, InstrValid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("rst_stall", {16'b0, StallCount}, 32'd0);
`endif
        step();
        reset_n = 1'b1;
        chk("idle_no_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential fetch, then a 5-cycle decode stall.
        do_fetch(32'h0, 32'h0022_1905);
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h4);
        do_fetch(32'h4, 32'h8C22_0003);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", Instruction, 32'h8C22_0003);
            chk("stall_pcout", PcOut, 32'h4);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, InstrValid}, 32'd1);
        end
`ifdef FETCH_PERF_COUNT_EN
        chk("stall_count", {16'b0, StallCount}, 32'd5);
`endif
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h8);

        // Redirects: jump, negative branch, jump-over-branch priority, positive branch.
        do_fetch(32'h8, 32'h0800_0003);
        consume(1'b1, 26'd3, 1'b0, 16'h0, 32'hC);
        do_fetch(32'hC, 32'h0000_0020);
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h10);
        do_fetch(32'h10, 32'h1000_FFFF);
        consume(1'b0, 26'h0, 1'b1, 16'hFFFF, 32'h10);
        do_fetch(32'h10, 32'h1000_FFFF);
        consume(1'b1, 26'h0, 1'b1, 16'hFFFF, 32'h0);
        do_fetch(32'h0, 32'h1000_0002);
        consume(1'b0, 26'h0, 1'b1, 16'h0002, 32'hC);

        // Flush in FETCH with a same-cycle ack: goes straight back to FETCH, low bits forced to 0.
`ifdef FETCH_PERF_COUNT_EN
        chk("stall_hold", {16'b0, StallCount}, 32'd5);
`endif
        Flush      = 1'b1;
        FlushPc    = 32'hFFFF_FFFF;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        step();
        Flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("flush_ack_valid", {31'b0, InstrValid}, 32'd0);
        chk("flush_ack_req", {31'b0, imem_req}, 32'd1);
        chk("flush_ack_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_COUNT_EN
        chk("stall_cleared", {16'b0, StallCount}, 32'd0);
`endif
        do_fetch(32'hFFFF_FFFC, 32'h0000_0001);
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h0);

        // Flush from FULL wins over a simultaneous jump consume.
        do_fetch(32'h0, 32'h0000_0002);
        Flush       = 1'b1;
        FlushPc     = 32'h7FFF_FFFC;
        DecodeReady = 1'b1;
        JumpEn      = 1'b1;
        JumpTarget  = 26'h155;
        step();
        Flush       = 1'b0;
        DecodeReady = 1'b0;
        JumpEn      = 1'b0;
        JumpTarget  = 26'h0;
        chk("flush_full_valid", {31'b0, InstrValid}, 32'd0);
        chk("flush_full_addr", imem_addr, 32'h7FFF_FFFC);
        do_fetch(32'h7FFF_FFFC, 32'h0000_0003);
        consume(1'b1, 26'd1, 1'b0, 16'h0, 32'h8000_0004);

        // Flush in FETCH without ack: the late ack is drained and discarded.
        Flush   = 1'b1;
        FlushPc = 32'h80;
        step();
        Flush   = 1'b0;
        chk("drain_req", {31'b0, imem_req}, 32'd0);
        chk("drain_valid", {31'b0, InstrValid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("drain_wait_req", {31'b0, imem_req}, 32'd0);
            chk("drain_wait_valid", {31'b0, InstrValid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("drain_discard_valid", {31'b0, InstrValid}, 32'd0);
        chk("drain_refetch_req", {31'b0, imem_req}, 32'd1);
        chk("drain_refetch_addr", imem_addr, 32'h80);
        do_fetch(32'h80, 32'h2000_0080);
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h84);

        // Asynchronous reset mid-fetch; an ack while idle after release is ignored.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, imem_req}, 32'd0);
        chk("async_rst_pcout", PcOut, 32'h0);
        chk("async_rst_instr", Instruction, 32'h0);
        step();
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("post_rst_valid", {31'b0, InstrValid}, 32'd0);
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h0000_0013);
        consume(1'b0, 26'h0, 1'b0, 16'h0, 32'h4);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
